// File: rtl/hamming_enc_stream.sv
// -----------------------------------------------------------------------------
// hamming_enc_stream
//
// Streaming Hamming encoder behind a two-stage elastic valid/ready pipeline.
// K = 2^R-R-1 data bits are encoded into an N = 2^R-1 bit codeword. Codeword
// position p (1..N) maps to data_out[p-1]. Parity bit P_i sits at p = 2^i.
// Data bits fill the remaining positions in ascending order. Each parity bit
// gives even parity over the positions that have bit i set. The block also
// counts the codewords it emits.
//
// Optional build macro:
//   HAM_SECDED_EN - adds data_out[N] = overall even parity of the codeword
//                   (SEC-DED). Without it data_out is N bits (pure SEC).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      data_in is valid
//   in_ready   out  1      encoder accepts data_in this cycle
//   data_in    in   K      data word
//   out_valid  out  1      data_out holds a valid codeword
//   out_ready  in   1      consumer accepts data_out this cycle
//   data_out   out  OW     codeword (N bits, or N+1 with HAM_SECDED_EN)
//   cw_count   out  CNT_W  codewords emitted since reset (wraps silently)
// -----------------------------------------------------------------------------
module hamming_enc_stream #(
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int K    = (1 << R) - R - 1,
  localparam int N    = (1 << R) - 1,
`ifdef HAM_SECDED_EN
  localparam int OW   = N + 1
`else
  localparam int OW   = N
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    data_out,
  output logic [CNT_W-1:0] cw_count
);

  // Builds the codeword: scatter data bits into the non-power-of-two
  // positions, then each parity bit covers the positions with bit i set.
  // Parity positions are still zero when the parities are formed, so they
  // do not disturb each other.
  function automatic logic [OW-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic         par;
    int           j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < R; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (((p >> i) & 1) != 0) begin
          par = par ^ cw[p-1];
        end
      end
      cw[(1 << i) - 1] = par;
    end
`ifdef HAM_SECDED_EN
    return {^cw, cw};
`else
    return cw;
`endif
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [K-1:0]     s1_data_q, s1_data_d;
  logic             s2_v_q, s2_v_d;
  logic [OW-1:0]    s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_adv;
  logic             s2_adv;
  logic [OW-1:0]    enc_word;

  // Encoder sits between the stages, so data_in never reaches data_out
  // combinationally.
  always_comb begin
    enc_word = encode(s1_data_q);
  end

  // Advance rules: a stage may load when it is empty or when the stage
  // downstream of it is moving. in_ready depends on out_ready only, never on
  // in_valid.
  always_comb begin
    s2_adv    = !s2_v_q || out_ready;
    s1_adv    = !s1_v_q || s2_adv;

    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    cnt_d     = cnt_q;

    if (s2_adv) begin
      s2_v_d    = s1_v_q;
      s2_data_d = enc_word;
    end
    if (s1_adv) begin
      s1_v_d    = in_valid;
      s1_data_d = data_in;
    end
    if (s2_v_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset drops words in flight and clears data and the
  // counter. A transfer in the reset cycle is therefore not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign data_out  = s2_data_q;
  assign cw_count  = cnt_q;

endmodule

// File: tb/tb_hamming_enc_stream.sv
module tb_hamming_enc_stream;

  localparam int R = 4;
  localparam int K = 11;
  localparam int N = 15;
`ifdef HAM_SECDED_EN
  localparam int OW = 16;
  localparam logic [OW-1:0] EXP_001 = 16'h8007;
  localparam logic [OW-1:0] EXP_7FF = 16'hFFFF;
`else
  localparam int OW = 15;
  localparam logic [OW-1:0] EXP_001 = 15'h0007;
  localparam logic [OW-1:0] EXP_7FF = 15'h7FFF;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [K-1:0]  data_in = '0;
  logic          in_ready, out_valid;
  logic [OW-1:0] data_out;
  logic [15:0]   cw_count;
  logic          in_ready4, out_valid4;
  logic [OW-1:0] data_out4;
  logic [3:0]    cw_count4;

  int errors = 0;
  int checks = 0;
  int flip_idx = 0;
  logic [OW-1:0] sb[$];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  hamming_enc_stream #(.R(R), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .cw_count(cw_count)
  );

  // Narrow-counter instance sharing the same stimulus, to see the wrap.
  hamming_enc_stream #(.R(R), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .data_in(data_in), .out_valid(out_valid4), .out_ready(out_ready),
    .data_out(data_out4), .cw_count(cw_count4)
  );

  // Reference encoder: parity bits are chosen so the syndrome (XOR of the
  // positions of all set bits) of the finished codeword is zero.
  function automatic logic [OW-1:0] enc_ref(input logic [K-1:0] d);
    logic [N-1:0] cw;
    int j;
    int syn;
    cw = '0;
    j = 0;
    syn = 0;
    for (int p = 1; p <= N; p++) begin
      if ($countones(p) != 1) begin
        cw[p-1] = d[j];
        if (d[j]) syn = syn ^ p;
        j++;
      end
    end
    for (int i = 0; i < R; i++) cw[(1 << i) - 1] = syn[i];
`ifdef HAM_SECDED_EN
    return {^cw, cw};
`else
    return cw;
`endif
  endfunction

  // Position syndrome of a codeword: zero when clean, error position when a
  // single bit is flipped.
  function automatic int syndrome(input logic [N-1:0] cw);
    int s;
    s = 0;
    for (int p = 1; p <= N; p++) if (cw[p-1]) s = s ^ p;
    return s;
  endfunction

  // One comparison: count it, and on a miss count the failure and report.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the input side and the consumer's ready for the next edge.
  task automatic applyStimulus(input logic v, input logic [K-1:0] d, input logic rdy);
    in_valid  = v;
    data_in   = d;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Back-to-back burst of n words starting at base, then drain the pipe.
  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, K'(base + i), 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    tick();
  endtask

  // Scoreboard monitor, sampled mid-cycle where inputs and outputs are
  // settled for the coming edge. Any valid output must match the oldest
  // outstanding word, which also proves it stays stable while stalled.
  always @(negedge clk) begin : monitor
    logic [N-1:0] bad;
    int e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("sb_data_out", 32'(data_out), 32'(sb[0]));
          checkOutput("sb_data_out4", 32'(data_out4), 32'(sb[0]));
        end
        checkOutput("syndrome_clean", 32'(syndrome(data_out[N-1:0])), 32'd0);
        e = flip_idx % N;
        bad = data_out[N-1:0] ^ (N'(1) << e);
        checkOutput("syndrome_flip", 32'(syndrome(bad)), 32'(e + 1));
`ifdef HAM_SECDED_EN
        checkOutput("overall_parity", 32'(^data_out), 32'd0);
`endif
        flip_idx++;
        if (out_ready && sb.size() > 0) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(enc_ref(data_in));
    end
  end

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cw_count", 32'(cw_count), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);

    // Single word: visible two edges after it is presented
    applyStimulus(1'b1, 11'h001, 1'b1);
    tick();
    checkOutput("t1_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_data", 32'(data_out), 32'(EXP_001));
    tick();

    // All-ones and all-zeros words back to back
    applyStimulus(1'b1, 11'h7FF, 1'b1);
    tick();
    applyStimulus(1'b1, 11'h000, 1'b1);
    tick();
    checkOutput("t2_ones", 32'(data_out), 32'(EXP_7FF));
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("t2_zeros_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_zeros", 32'(data_out), 32'd0);
    tick();
    checkOutput("t2_count", 32'(cw_count), 32'd3);

    // Eight-word burst at full throughput
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, K'(11'h040 + i), 1'b1);
      tick();
      checkOutput("t3_valid", 32'(out_valid), (i >= 1) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("t3_last_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("t3_idle", 32'(out_valid), 32'd0);
    checkOutput("t3_count", 32'(cw_count), 32'd8);

    // Backpressure: five stalled cycles, then a simultaneous in/out transfer
    doReset();
    applyStimulus(1'b1, 11'h100, 1'b0);
    tick();
    checkOutput("t4_ready_after1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 11'h101, 1'b0);
    tick();
    checkOutput("t4_ready_after2", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, K'(11'h102 + i), 1'b0);
      tick();
      checkOutput("t4_ready_stall", 32'(in_ready), 32'd0);
      checkOutput("t4_valid_stall", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b1, 11'h1A5, 1'b1);
    #1;
    checkOutput("t4_ready_full_release", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) tick();
    checkOutput("t4_drained", 32'(sb.size()), 32'd0);
    checkOutput("t4_count", 32'(cw_count), 32'd3);

    // Reset with both stages full, consumer ready in the reset cycle
    doReset();
    applyStimulus(1'b1, 11'h055, 1'b0);
    tick();
    applyStimulus(1'b1, 11'h0AA, 1'b0);
    tick();
    checkOutput("t5_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 11'h3FF, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t5_count", 32'(cw_count), 32'd0);
    checkOutput("t5_data_out", 32'(data_out), 32'd0);

    // Counter wrap on the 4-bit instance
    stream(15, 11'h200);
    checkOutput("t6_count4_15", 32'(cw_count4), 32'd15);
    stream(1, 11'h300);
    checkOutput("t6_count4_wrap", 32'(cw_count4), 32'd0);
    checkOutput("t6_count16", 32'(cw_count), 32'd16);
    stream(1, 11'h301);
    checkOutput("t6_count4_end", 32'(cw_count4), 32'd1);

    // Exhaustive sweep of every data word
    doReset();
    stream(2048, 0);
    checkOutput("sweep_count", 32'(cw_count), 32'd2048);
    checkOutput("sweep_count4", 32'(cw_count4), 32'd0);

    // Random valid and ready patterns
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), K'($urandom), 1'($urandom));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (4) tick();
    checkOutput("random_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
